// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
//   Shared CPU/memory types: the 32-bit machine word and the RAM handshake
//   state reported by the memory side. Also holds the largest supported RAM
//   access latency, which sets the width of the responder's wait counter.
// -----------------------------------------------------------------------------
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    // Handshake state driven by the memory back to the controller.
    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;

    // Largest programmable number of BUSY cycles before ACCESS.
    localparam int unsigned RAM_LAT_MAX = 15;

endpackage : cpu_types_pkg

// File: rtl/ram_responder_if.sv
// -----------------------------------------------------------------------------
// ram_responder_if
//   RAM port between the coherence/arbitration controller (master) and the
//   memory responder (slave).
//   ramREN / ramWEN : read / write request, held until ACCESS is observed
//   ramaddr         : byte address, word aligned
//   ramstore        : write data
//   ramload         : read data, valid while ramstate == ACCESS for a read
//   ramstate        : FREE / BUSY / ACCESS / ERROR handshake
// -----------------------------------------------------------------------------
interface ram_responder_if;
    import cpu_types_pkg::*;

    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    modport master (
        output ramREN, ramWEN, ramaddr, ramstore,
        input  ramload, ramstate
    );

    modport slave (
        input  ramREN, ramWEN, ramaddr, ramstore,
        output ramload, ramstate
    );

endinterface : ram_responder_if

// File: rtl/ram_array.sv
// -----------------------------------------------------------------------------
// ram_array
//   Single-port DEPTH x 32 synchronous storage with a registered read.
//   CLK   : clock, rising edge
//   nRST  : async active-low reset, clears only the read-data register
//   we    : write idx with wdata at the clock edge
//   re    : capture mem[idx] into rdata at the clock edge (else rdata holds)
//   idx   : word index
//   wdata : write data
//   rdata : registered read data
// -----------------------------------------------------------------------------
module ram_array
    import cpu_types_pkg::*;
#(
    parameter int unsigned DEPTH = 16384,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] idx,
    input  word_t         wdata,
    output word_t         rdata
);

    word_t mem [DEPTH];

    // NOTE: storage has no reset branch so it maps onto block RAM; only the
    // output register below is reset.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule : ram_array

// File: rtl/ram_responder.sv
// -----------------------------------------------------------------------------
// ram_responder
//   Memory-side responder for the shared RAM port. Accepts one read or write
//   at a time, reports BUSY for LAT cycles and then ACCESS, and backs a
//   word-addressed ram_array.
//   CLK  : clock, rising edge
//   nRST : asynchronous active-low reset
//   ram  : ram_responder_if.slave (requests in, ramload/ramstate out)
// Parameters: LAT (BUSY cycles, 0..RAM_LAT_MAX), DEPTH (words, power of two),
//   AW (word-index width).
// -----------------------------------------------------------------------------
module ram_responder
    import cpu_types_pkg::*;
#(
    parameter int unsigned LAT   = 2,
    parameter int unsigned DEPTH = 16384,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic            CLK,
    input  logic            nRST,
    ram_responder_if.slave  ram
);

    localparam int unsigned    CW       = $clog2(RAM_LAT_MAX + 1);
    localparam bit             ZERO_LAT = (LAT == 0);
    // A WAIT period (only reachable on a request change when LAT is 0) always
    // lasts at least one cycle, so a write's ACCESS never collides with the
    // next read on the single array port.
    localparam logic [CW-1:0]  LAST     = ZERO_LAT ? '0 : CW'(LAT - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_ERR} fsm_t;

    fsm_t          state;
    ramstate_t     rstate;
    logic [CW-1:0] cnt;
    logic          lat_wr;
    logic [AW-1:0] lat_idx;
    word_t         lat_data;

    logic          req_any;
    logic          req_bad;
    logic          req_ok;
    logic          same;
    logic [AW-1:0] req_idx;
    logic          rd_en;
    logic          wr_en;
    logic [AW-1:0] arr_idx;
    word_t         load;

    assign req_idx = ram.ramaddr[AW+1:2];
    assign req_any = ram.ramREN || ram.ramWEN;

    // Illegal: both strobes, misaligned, or beyond the array.
    assign req_bad = req_any &&
                     ((ram.ramREN && ram.ramWEN) ||
                      (ram.ramaddr[1:0] != 2'b00) ||
                      ((ram.ramaddr >> (AW + 2)) != '0));
    assign req_ok  = req_any && !req_bad;

    // Request matches the latched one; write data only matters for writes.
    assign same = (ram.ramWEN == lat_wr) && (req_idx == lat_idx) &&
                  (!ram.ramWEN || (ram.ramstore == lat_data));

    // Capture read data on every edge that enters or stays in ACCESS for a read.
    assign rd_en = req_ok && !ram.ramWEN &&
                   (((state == S_IDLE) && ZERO_LAT) ||
                    ((state == S_WAIT) && same && (cnt == LAST)) ||
                    ((state == S_ACCESS) && same));

    // Writes commit at the end of the ACCESS cycle from the latched request; an
    // async reset forces S_IDLE first, so a reset ACCESS cycle never commits.
    assign wr_en   = (state == S_ACCESS) && lat_wr;
    assign arr_idx = wr_en ? lat_idx : req_idx;

    ram_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .CLK   (CLK),
        .nRST  (nRST),
        .we    (wr_en),
        .re    (rd_en),
        .idx   (arr_idx),
        .wdata (lat_data),
        .rdata (load)
    );

    assign ram.ramload  = load;
    assign ram.ramstate = rstate;

    // NOTE: all state here is sequential and uses non-blocking assignments so
    // every register samples the pre-edge values of its peers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= S_IDLE;
            rstate   <= FREE;
            cnt      <= '0;
            lat_wr   <= 1'b0;
            lat_idx  <= '0;
            lat_data <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (req_bad) begin
                        state  <= S_ERR;
                        rstate <= ERROR;
                    end else if (req_ok) begin
                        lat_wr   <= ram.ramWEN;
                        lat_idx  <= req_idx;
                        lat_data <= ram.ramstore;
                        cnt      <= '0;
                        if (ZERO_LAT) begin
                            state  <= S_ACCESS;
                            rstate <= ACCESS;
                        end else begin
                            state  <= S_WAIT;
                            rstate <= BUSY;
                        end
                    end
                end

                S_WAIT: begin
                    if (!req_any) begin
                        state  <= S_IDLE;
                        rstate <= FREE;
                    end else if (req_bad) begin
                        state  <= S_ERR;
                        rstate <= ERROR;
                    end else if (!same) begin
                        // Changed request: restart the BUSY period on the new one.
                        lat_wr   <= ram.ramWEN;
                        lat_idx  <= req_idx;
                        lat_data <= ram.ramstore;
                        cnt      <= '0;
                    end else if (cnt == LAST) begin
                        state  <= S_ACCESS;
                        rstate <= ACCESS;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_ACCESS: begin
                    if (!req_any) begin
                        state  <= S_IDLE;
                        rstate <= FREE;
                    end else if (req_bad) begin
                        state  <= S_ERR;
                        rstate <= ERROR;
                    end else if (!same) begin
                        // Back-to-back request: fresh BUSY period, no FREE gap.
                        lat_wr   <= ram.ramWEN;
                        lat_idx  <= req_idx;
                        lat_data <= ram.ramstore;
                        cnt      <= '0;
                        state    <= S_WAIT;
                        rstate   <= BUSY;
                    end
                end

                S_ERR: begin
                    if (!req_any) begin
                        state  <= S_IDLE;
                        rstate <= FREE;
                    end else if (req_ok) begin
                        lat_wr   <= ram.ramWEN;
                        lat_idx  <= req_idx;
                        lat_data <= ram.ramstore;
                        cnt      <= '0;
                        state    <= S_WAIT;
                        rstate   <= BUSY;
                    end
                end

                default: begin
                    state  <= S_IDLE;
                    rstate <= FREE;
                end
            endcase
        end
    end

endmodule : ram_responder

// File: tb/tb_ram_responder.sv
// -----------------------------------------------------------------------------
// tb_ram_responder
//   Self-checking bench for ram_responder. A LAT=2 instance carries directed
//   and random traffic; a LAT=0 instance covers the zero-latency case. The
//   reference is a word-indexed associative array plus the expected handshake
//   sequence (prev state, LAT x BUSY, ACCESS) for each request. Inputs are
//   driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_ram_responder;
    import cpu_types_pkg::*;

    localparam int unsigned LAT2      = 2;
    localparam int unsigned POOL      = 16;
    localparam logic [31:0] POOL_BASE = 32'h0000_1000;

    logic clk;
    logic rst_n;

    ram_responder_if i2 ();
    ram_responder_if i0 ();

    ram_responder #(.LAT(LAT2)) u_dut (
        .CLK  (clk),
        .nRST (rst_n),
        .ram  (i2)
    );

    ram_responder #(.LAT(0)) u_dut0 (
        .CLK  (clk),
        .nRST (rst_n),
        .ram  (i0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_total = 0;
    int    n_pass  = 0;
    word_t model [int];
    word_t exp_load = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Entered at a falling edge in cycle N; returns at the falling edge of the
    // ACCESS cycle with the request still held.
    task automatic do_txn(input bit wr, input logic [31:0] addr, input word_t data,
                          input ramstate_t prev, input string tag);
        i2.ramREN   = !wr;
        i2.ramWEN   = wr;
        i2.ramaddr  = addr;
        i2.ramstore = wr ? data : word_t'($urandom);
        check({tag, "_prev"}, i2.ramstate, prev);
        for (int c = 1; c <= int'(LAT2) + 1; c++) begin
            @(negedge clk);
            check({tag, "_state"}, i2.ramstate, (c <= int'(LAT2)) ? BUSY : ACCESS);
        end
        if (wr) begin
            check({tag, "_wr_load_hold"}, i2.ramload, exp_load);
            model[int'(addr >> 2)] = data;
        end else begin
            exp_load = model[int'(addr >> 2)];
            check({tag, "_rd_load"}, i2.ramload, exp_load);
        end
    endtask

    task automatic idle(input string tag);
        i2.ramREN = 1'b0;
        i2.ramWEN = 1'b0;
        @(negedge clk);
        check(tag, i2.ramstate, FREE);
    endtask

    logic [31:0] dir_addrs [8] = '{32'h10, 32'h80, 32'h84, 32'h100,
                                   32'h104, 32'h200, 32'h204, 32'h300};

    initial begin
        bit          wr;
        logic [31:0] a;
        logic [31:0] last_addr;
        ramstate_t   prev;
        word_t       saved;
        word_t       d0;
        int          hold;

        rst_n = 1'b0;
        i2.ramREN = 1'b0; i2.ramWEN = 1'b0; i2.ramaddr = '0; i2.ramstore = '0;
        i0.ramREN = 1'b0; i0.ramWEN = 1'b0; i0.ramaddr = '0; i0.ramstore = '0;
        repeat (2) @(negedge clk);
        check("reset_state", i2.ramstate, FREE);
        check("reset_load", i2.ramload, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Preload every address the bench will read.
        foreach (dir_addrs[k]) begin
            do_txn(1'b1, dir_addrs[k], (dir_addrs[k] == 32'h80) ? 32'h0 : word_t'($urandom),
                   FREE, "pre");
            idle("pre_idle");
        end
        for (int k = 0; k < int'(POOL); k++) begin
            do_txn(1'b1, POOL_BASE + 32'(4 * k), word_t'($urandom), FREE, "pool");
            idle("pool_idle");
        end

        // Write then read back.
        do_txn(1'b1, 32'h40, 32'hDEAD_BEEF, FREE, "wr40");
        idle("wr40_free");
        do_txn(1'b0, 32'h40, 32'h0, FREE, "rd40");
        check("rd40_value", i2.ramload, 32'hDEAD_BEEF);
        idle("rd40_free");

        // Address switch during the first BUSY cycle restarts the count.
        i2.ramREN = 1'b1; i2.ramWEN = 1'b0; i2.ramaddr = 32'h100;
        check("sw_prev", i2.ramstate, FREE);
        @(negedge clk);
        check("sw_busy", i2.ramstate, BUSY);
        do_txn(1'b0, 32'h104, 32'h0, BUSY, "sw104");
        idle("sw_free");

        // Back-to-back reads with no FREE gap.
        do_txn(1'b0, 32'h200, 32'h0, FREE, "b2b0");
        do_txn(1'b0, 32'h204, 32'h0, ACCESS, "b2b1");
        idle("b2b_free");

        // Request dropped during WAIT: nothing written.
        i2.ramREN = 1'b0; i2.ramWEN = 1'b1; i2.ramaddr = 32'h300; i2.ramstore = 32'hFFFF_0000;
        @(negedge clk);
        check("drop_busy", i2.ramstate, BUSY);
        idle("drop_free");
        do_txn(1'b0, 32'h300, 32'h0, FREE, "drop_rd");
        idle("drop_rd_free");

        // Illegal requests.
        i2.ramREN = 1'b1; i2.ramWEN = 1'b1; i2.ramaddr = 32'h10; i2.ramstore = 32'hBAD0_BAD0;
        check("err_prev", i2.ramstate, FREE);
        @(negedge clk);
        check("err_both", i2.ramstate, ERROR);
        check("err_load_hold", i2.ramload, exp_load);
        i2.ramWEN = 1'b0; i2.ramaddr = 32'h13;
        @(negedge clk);
        check("err_misalign", i2.ramstate, ERROR);
        i2.ramaddr = 32'h0001_0000;
        @(negedge clk);
        check("err_range", i2.ramstate, ERROR);
        idle("err_free");
        do_txn(1'b0, 32'h10, 32'h0, FREE, "err_rd10");
        idle("err_rd_free");

        // Zero-latency instance.
        d0 = word_t'($urandom);
        i0.ramREN = 1'b0; i0.ramWEN = 1'b1; i0.ramaddr = 32'h8; i0.ramstore = d0;
        check("l0_wr_prev", i0.ramstate, FREE);
        @(negedge clk);
        check("l0_wr_access", i0.ramstate, ACCESS);
        i0.ramWEN = 1'b0;
        @(negedge clk);
        check("l0_wr_free", i0.ramstate, FREE);
        i0.ramREN = 1'b1;
        @(negedge clk);
        check("l0_rd_access", i0.ramstate, ACCESS);
        check("l0_rd_load", i0.ramload, d0);
        repeat (2) begin
            @(negedge clk);
            check("l0_hold_state", i0.ramstate, ACCESS);
            check("l0_hold_load", i0.ramload, d0);
        end
        i0.ramREN = 1'b0;
        @(negedge clk);
        check("l0_free", i0.ramstate, FREE);

        // Reset during the first BUSY cycle of a write.
        i2.ramREN = 1'b0; i2.ramWEN = 1'b1; i2.ramaddr = 32'h80; i2.ramstore = 32'h1234_5678;
        check("rstw_prev", i2.ramstate, FREE);
        @(negedge clk);
        check("rstw_busy", i2.ramstate, BUSY);
        rst_n = 1'b0;
        #1;
        check("rstw_state", i2.ramstate, FREE);
        check("rstw_load", i2.ramload, 32'h0);
        exp_load = '0;
        i2.ramWEN = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_txn(1'b0, 32'h80, 32'h0, FREE, "rstw_rd80");
        check("rstw_old_value", i2.ramload, 32'h0);
        idle("rstw_free");

        // Reset asserted inside a write's ACCESS cycle: not committed.
        saved = model[int'(32'h84 >> 2)];
        do_txn(1'b1, 32'h84, 32'hCAFE_F00D, FREE, "rsta");
        model[int'(32'h84 >> 2)] = saved;
        rst_n = 1'b0;
        #1;
        check("rsta_state", i2.ramstate, FREE);
        exp_load = '0;
        i2.ramWEN = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_txn(1'b0, 32'h84, 32'h0, FREE, "rsta_rd84");
        idle("rsta_free");

        // Random traffic over the pool, mixing idles, holds and chaining.
        prev      = FREE;
        last_addr = '1;
        for (int it = 0; it < 200; it++) begin
            wr = 1'($urandom_range(0, 1));
            do begin
                a = POOL_BASE + 32'(4 * $urandom_range(0, POOL - 1));
            end while (prev == ACCESS && a == last_addr);
            do_txn(wr, a, word_t'($urandom), prev, "rnd");
            hold = int'($urandom_range(0, 2));
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check("rnd_hold_state", i2.ramstate, ACCESS);
                check("rnd_hold_load", i2.ramload, exp_load);
            end
            if ($urandom_range(0, 1) == 1) begin
                idle("rnd_free");
                prev = FREE;
            end else begin
                prev = ACCESS;
            end
            last_addr = a;
        end
        if (prev == ACCESS) begin
            idle("rnd_final_free");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_ram_responder
